hood_display_scan: RTL
======================

// Module: hood_display_scan
// PURPOSE
//   Display-side consumer of the hood controller's status outputs (time of day, work time, countdown, smoke level,
//   hand-gesture time, remind). Snapshots the selected set of values once per frame and converts each 6-bit binary
//   field to two BCD digits. Time-multiplexes the digits onto one 8-digit common-anode-select seven-segment bank.
//   Sits between the hood top level and the board pins, replacing the empty output stage.
// PARAMETERS
//   SCAN_DIV   100_000      clk cycles per digit slot (1 kHz digit rate at 100 MHz)
//   BLINK_DIV  50_000_000   clk cycles per blink half-period while remind=1 (0.5 s)
// PORTS
//   clk              in   1  system clock
//   reset            in   1  asynchronous, active-low reset
//   power_on         in   1  hood power state; 0 blanks the display
//   disp_mode        in   2  0=time of day, 1=work time, 2=smoke lvl+countdown, 3=hand time
//   cur_hour         in   6  binary hour, 0..63
//   cur_min          in   6  binary minute
//   cur_second       in   6  binary second
//   work_hours       in   6  accumulated work hours
//   work_minutes     in   6  accumulated work minutes
//   countsecond      in   6  mode countdown seconds
//   state_smoke_lvl  in   4  smoke level code, shown as decimal 0..15
//   hand_time        in   6  gesture-switch time
//   remind           in   1  cleaning reminder; 1 makes the display blink
//   an               out  8  digit enables, active-high, an[0]=rightmost digit
//   seg              out  8  {dp,g,f,e,d,c,b,a}, active-high; dp is always 0
// BEHAVIOUR
//   Reset (async, reset=0): an=0, seg=0, scan_cnt=0, digit idx=0, blink_cnt=0, blink_on=1, snapshot regs=0.
//   Scan counter: scan_cnt counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and idx advances (7 wraps to 0).
//   Frame start: the tick on which idx goes 7->0. On that same edge, disp_mode and all value inputs are latched into the snapshot.
//     Input changes mid-frame are never visible until the next frame, so no digit tearing occurs.
//   Output timing: an/seg are registered and update on the tick edge. The new idx is reflected in the same
//     registered update, giving a 1-cycle latency from tick to pins. One-hot an=(1<<idx) when visible.
//   BCD: for v in 0..63, tens=v/10 and ones=v%10 (63 -> "6","3"). No clamping. Leading zeros are shown.
//   Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F '-'=40 'L'=38 blank=00.
//   Digit map, d7..d0 (d0 = idx 0):
//     mode0: H1 H0 - M1 M0 - S1 S0        (time of day)
//     mode1: blank blank W1 W0 - m1 m0 blank  (work hours - work minutes)
//     mode2: L lvl1 lvl0 blank blank blank C1 C0  (smoke level, countdown)
//     mode3: blank x6 T1 T0                (hand_time)
//     Blank glyph digits still drive an=(1<<idx) with seg=00.
//   Blink: when snapshot remind=1, blink_cnt counts 0..BLINK_DIV-1 and toggles blink_on on wrap.
//     While blink_on=0, an=0 and seg=0. When remind=0, blink_cnt is held at 0 and blink_on is held at 1.
//   Power off: power_on=0 (sampled live, not snapshotted) forces an=0 and seg=0 from the next clk edge.
//     Scanning and snapshotting continue. On power_on 0->1, output resumes at the current idx with no reset of the counters.
//   Simultaneous events: frame start combined with a remind toggle -> the new remind takes effect in that frame.
//     Power off takes priority over blink; blink takes priority over glyphs.
//   Reset mid-frame: all state clears immediately. The first snapshot is taken at the next frame start,
//     so zeros are displayed until then.
// TESTING  (SCAN_DIV=4, BLINK_DIV=16 for simulation)
//   1. Reset held low, random inputs -> an=00, seg=00. Release -> after the first frame, mode0 12:34:56
//      gives the d7..d0 glyphs 06,5B,40,4F,66,40,6D,7D.
//   2. Mode0, cur_second changed 56->57 mid-frame -> d0 stays 7D for the rest of the frame. It becomes 07 after the next 7->0 wrap.
//   3. Boundary: cur_hour=63, cur_min=0, cur_second=9 -> d7=7D, d6=4F, d4=3F, d3=3F, d1=3F, d0=6F.
//   4. Mode2, state_smoke_lvl=3, countsecond=60 -> d7=38, d6=3F, d5=4F, d1=7D, d0=3F. Digits d4..d2 are enabled with seg=00.
//   5. remind=1 -> an/seg alternate between active for 16 cycles and all-zero for 16 cycles. power_on=0 during this
//      -> an=0 on the next edge regardless of blink phase.
//   6. Assert reset at idx=5 mid-slot -> an=0 and seg=0 asynchronously. After release, idx restarts at 0 with snapshot values of 0.

Source files
------------

// File: rtl/hood_display_scan.sv
// hood_display_scan
// Captures the hood controller's status values once per display frame and shows them on an
// 8-digit seven-segment bank. Each 6-bit binary value is split into two decimal digits. The
// digits are scanned one at a time. Power-off blanks the bank, and the remind input makes it blink.
module hood_display_scan #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic [1:0] disp_mode,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_second,
  input  logic [5:0] work_hours,
  input  logic [5:0] work_minutes,
  input  logic [5:0] countsecond,
  input  logic [3:0] state_smoke_lvl,
  input  logic [5:0] hand_time,
  input  logic       remind,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Glyph codes. Values 0..9 are decimal digits. The remaining codes are symbols.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_L     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd12;

  // One frame's worth of displayed values. remind is included so blinking changes only at frame starts.
  typedef struct packed {
    logic [1:0] mode;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] work_h;
    logic [5:0] work_m;
    logic [5:0] count_s;
    logic [3:0] smoke_lvl;
    logic [5:0] hand;
    logic       remind;
  } snap_t;

  // Segment pattern {dp,g,f,e,d,c,b,a} for a glyph code. dp always stays dark.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] pat;
    case (code)
      4'd0:      pat = 8'h3F;
      4'd1:      pat = 8'h06;
      4'd2:      pat = 8'h5B;
      4'd3:      pat = 8'h4F;
      4'd4:      pat = 8'h66;
      4'd5:      pat = 8'h6D;
      4'd6:      pat = 8'h7D;
      4'd7:      pat = 8'h07;
      4'd8:      pat = 8'h7F;
      4'd9:      pat = 8'h6F;
      CODE_DASH: pat = 8'h40;
      CODE_L:    pat = 8'h38;
      default:   pat = 8'h00;
    endcase
    return pat;
  endfunction

  // Binary 0..63 to {tens, ones}. A compare chain is used because the range is small, so no divider is needed.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] base;
    if (v >= 6'd60)      begin tens = 4'd6; base = 6'd60; end
    else if (v >= 6'd50) begin tens = 4'd5; base = 6'd50; end
    else if (v >= 6'd40) begin tens = 4'd4; base = 6'd40; end
    else if (v >= 6'd30) begin tens = 4'd3; base = 6'd30; end
    else if (v >= 6'd20) begin tens = 4'd2; base = 6'd20; end
    else if (v >= 6'd10) begin tens = 4'd1; base = 6'd10; end
    else                 begin tens = 4'd0; base = 6'd0;  end
    return {tens, 4'(v - base)};
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  snap_t              snap_q, snap_d, live_snap;
  logic [7:0]         an_q, an_d, seg_q, seg_d;

  logic       tick, frame_start, visible;
  logic [7:0] bcd_hour, bcd_min, bcd_sec, bcd_wh, bcd_wm, bcd_cs, bcd_lvl, bcd_hand;
  logic [3:0] code [8];
  logic [3:0] digit_code;

  assign live_snap = '{
    mode:      disp_mode,
    hour:      cur_hour,
    minute:    cur_min,
    second:    cur_second,
    work_h:    work_hours,
    work_m:    work_minutes,
    count_s:   countsecond,
    smoke_lvl: state_smoke_lvl,
    hand:      hand_time,
    remind:    remind
  };

  // Scan timing, frame snapshot and blink phase. The outputs below use the next-state values, so a tick
  // or frame start appears on the pins after exactly one edge.
  always_comb begin
    tick        = (scan_cnt_q == SCAN_LAST);
    frame_start = tick && (idx_q == 3'd7);
    scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    snap_d      = frame_start ? live_snap : snap_q;

    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!snap_d.remind) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // Digit map for the active mode (code[0] is the rightmost digit), then select the digit being scanned.
  always_comb begin
    bcd_hour = to_bcd(snap_d.hour);
    bcd_min  = to_bcd(snap_d.minute);
    bcd_sec  = to_bcd(snap_d.second);
    bcd_wh   = to_bcd(snap_d.work_h);
    bcd_wm   = to_bcd(snap_d.work_m);
    bcd_cs   = to_bcd(snap_d.count_s);
    bcd_lvl  = to_bcd({2'b00, snap_d.smoke_lvl});
    bcd_hand = to_bcd(snap_d.hand);

    for (int i = 0; i < 8; i++) code[i] = CODE_BLANK;
    case (snap_d.mode)
      2'd0: begin
        code[7] = bcd_hour[7:4]; code[6] = bcd_hour[3:0]; code[5] = CODE_DASH;
        code[4] = bcd_min[7:4];  code[3] = bcd_min[3:0];  code[2] = CODE_DASH;
        code[1] = bcd_sec[7:4];  code[0] = bcd_sec[3:0];
      end
      2'd1: begin
        code[5] = bcd_wh[7:4]; code[4] = bcd_wh[3:0]; code[3] = CODE_DASH;
        code[2] = bcd_wm[7:4]; code[1] = bcd_wm[3:0];
      end
      2'd2: begin
        code[7] = CODE_L;
        code[6] = bcd_lvl[7:4]; code[5] = bcd_lvl[3:0];
        code[1] = bcd_cs[7:4];  code[0] = bcd_cs[3:0];
      end
      default: begin
        code[1] = bcd_hand[7:4]; code[0] = bcd_hand[3:0];
      end
    endcase

    digit_code = code[idx_d];
    // Power-off overrides blink. Blink overrides the glyph. Blank glyphs still enable their digit.
    visible = power_on && blink_on_d;
    an_d    = visible ? (8'd1 << idx_d) : 8'd0;
    seg_d   = visible ? glyph(digit_code) : 8'd0;
  end

  // State and output registers. An asynchronous reset clears everything, including the snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      snap_q      <= '0;
      an_q        <= 8'd0;
      seg_q       <= 8'd0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
